// File: rtl/round_robin_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter: pointer sizing.
package round_robin_arbiter_pkg;

    // Index width for a client count; never below one bit.
    function automatic int unsigned ptr_width(input int unsigned clients);
        return (clients <= 2) ? 1 : $clog2(clients);
    endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_pick.sv
// Rotating priority encoder: first eligible client after `last`, wrapping, ending at `last`.
module rr_pick
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned CLIENTS = 32,
    parameter int unsigned PTR_W   = ptr_width(CLIENTS)
) (
    input  logic [CLIENTS-1:0] elig,
    input  logic [PTR_W-1:0]   last,
    output logic               valid,
    output logic [PTR_W-1:0]   winner
);

    int unsigned      pos;
    logic [PTR_W-1:0] idx;

    // Walk offsets 1..CLIENTS from last; the first hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        pos    = 0;
        idx    = '0;
        for (int unsigned k = 1; k <= CLIENTS; k++) begin
            pos = int'(last) + k;
            if (pos >= CLIENTS) begin
                pos = pos - CLIENTS;
            end
            idx = PTR_W'(pos);
            if (!valid && elig[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant, stall freeze and synchronous reset.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned CLIENTS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLIENTS-1:0] request,
    input  logic               stall,
    output logic [CLIENTS-1:0] grant
);

    localparam int unsigned PTR_W = ptr_width(CLIENTS);

    logic [PTR_W-1:0]   last;
    logic [CLIENTS-1:0] elig;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_winner;

    // A client granted this cycle may still be requesting, so mask it out.
    assign elig = request & ~grant;

    rr_pick #(
        .CLIENTS (CLIENTS),
        .PTR_W   (PTR_W)
    ) u_pick (
        .elig   (elig),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            grant <= '0;
            last  <= PTR_W'(CLIENTS - 1);
        end else if (stall || !pick_valid) begin
            grant <= '0;
        end else begin
            grant <= CLIENTS'(1) << pick_winner;
            last  <= pick_winner;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter: directed scenarios plus random traffic.
module tb_round_robin_arbiter;

    localparam int N = 32;

    logic         clock;
    logic         reset;
    logic [N-1:0] request;
    logic         stall;
    logic [N-1:0] grant;

    logic [N-1:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    int m_last  = N - 1;
    int m_grant = -1;

    round_robin_arbiter #(.CLIENTS(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .stall   (stall),
        .grant   (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs and predict the grant visible after the coming edge.
    task automatic step(input logic [N-1:0] req, input logic stl, input logic rst);
        int best;
        int bd;
        int d;
        logic [N-1:0] e;
        @(negedge clock);
        request = req;
        stall   = stl;
        reset   = rst;
        best = -1;
        bd   = N;
        if (rst) begin
            m_last = N - 1;
        end else if (!stl) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && i != m_grant) begin
                    d = (i - m_last - 1 + 2 * N) % N;
                    if (d < bd) begin
                        bd   = d;
                        best = i;
                    end
                end
            end
            if (best >= 0) m_last = best;
        end
        m_grant = best;
        e = '0;
        if (best >= 0) e[best] = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: grant is presented every cycle; compare against the oldest prediction.
    always @(posedge clock) begin
        logic [N-1:0] exp_v;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            compared++;
            if (grant !== exp_v) begin
                mismatched++;
                $display("FAIL grant cycle %0d: got %h, required %h", cycle, grant, exp_v);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] ones;
        ones    = '1;
        request = '0;
        stall   = 1'b0;
        reset   = 1'b1;

        repeat (2) step('0, 1'b0, 1'b1);
        repeat (3) step('0, 1'b0, 1'b0);

        // Single persistent requester alternates grant / idle.
        repeat (6) step(N'(1) << 5, 1'b0, 1'b0);
        repeat (2) step('0, 1'b0, 1'b0);

        // Full contention walks the clients in order, then reset mid-stream.
        repeat (70) step(ones, 1'b0, 1'b0);
        step(ones, 1'b0, 1'b1);
        repeat (6) step(ones, 1'b0, 1'b0);

        // Priority rotation from last=5 with clients 3 and 9 pending.
        step('0, 1'b0, 1'b1);
        step(N'(1) << 5, 1'b0, 1'b0);
        repeat (4) step((N'(1) << 3) | (N'(1) << 9), 1'b0, 1'b0);
        repeat (2) step('0, 1'b0, 1'b0);

        // Stall holds off a pending request, including a stall landing on a live grant.
        repeat (4) step(N'(1) << 1, 1'b1, 1'b0);
        repeat (3) step(N'(1) << 1, 1'b0, 1'b0);
        step(ones, 1'b0, 1'b0);
        repeat (2) step(ones, 1'b1, 1'b0);
        repeat (3) step(ones, 1'b0, 1'b0);

        // Random traffic with occasional stall and reset.
        for (int c = 0; c < 600; c++) begin
            r = '0;
            for (int i = 0; i < N; i++) begin
                if ((c / 100) % 2 == 0) r[i] = ($urandom_range(0, 7) == 0);
                else r[i] = ($urandom_range(0, 3) != 0);
            end
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
        end
        step('0, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
